// File: rtl/ip_rx_pkg.sv
// Shared definitions for the IPv4 receive stage: protocol constants, IPv4
// header byte offsets and the receive FSM state type.
package ip_rx_pkg;

  localparam logic [7:0]  IP_PROTO_UDP = 8'd17;
  localparam logic [3:0]  IP_VERSION4  = 4'd4;
  localparam logic [3:0]  IP_MIN_IHL   = 4'd5;
  localparam logic [15:0] UDP_HDR_LEN  = 16'd8;

  // Byte offsets inside the IPv4 header
  localparam logic [15:0] OFF_VER_IHL   = 16'd0;
  localparam logic [15:0] OFF_TOTLEN_HI = 16'd2;
  localparam logic [15:0] OFF_TOTLEN_LO = 16'd3;
  localparam logic [15:0] OFF_FRAG_HI   = 16'd6;
  localparam logic [15:0] OFF_FRAG_LO   = 16'd7;
  localparam logic [15:0] OFF_PROTO     = 16'd9;
  localparam logic [15:0] OFF_SRC0      = 16'd12;
  localparam logic [15:0] OFF_SRC1      = 16'd13;
  localparam logic [15:0] OFF_SRC2      = 16'd14;
  localparam logic [15:0] OFF_SRC3      = 16'd15;
  localparam logic [15:0] OFF_DST0      = 16'd16;
  localparam logic [15:0] OFF_DST1      = 16'd17;
  localparam logic [15:0] OFF_DST2      = 16'd18;
  localparam logic [15:0] OFF_DST3      = 16'd19;
  localparam logic [15:0] MIN_HDR_LEN   = 16'd20;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } ip_rx_state_e;

endpackage

// File: rtl/ip_hdr_csum.sv
// IPv4 header checksum accumulator (ones' complement, 16-bit words built
// from byte pairs).
//   clk, reset_n : clock, async active-low reset
//   clr          : clear accumulator (wins over add_en)
//   add_en       : add byte_in to the accumulator
//   odd_sel      : 0 = byte is the high half of a word, 1 = low half
//   byte_in      : header byte
//   csum_ok      : folded sum including byte_in equals 16'hFFFF; lets the
//                  decision be taken on the same cycle as the last header byte
module ip_hdr_csum (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       add_en,
  input  logic       odd_sel,
  input  logic [7:0] byte_in,
  output logic       csum_ok
);

  logic [15:0] acc_q, acc_d;
  logic [16:0] sum;
  logic [15:0] folded;

  always_comb begin
    sum    = {1'b0, acc_q} + (odd_sel ? {9'd0, byte_in} : {1'b0, byte_in, 8'd0});
    // end-around carry; acc <= FFFF and addend <= FF00 so one fold suffices
    folded = sum[15:0] + {15'd0, sum[16]};
    acc_d  = acc_q;
    if (clr)         acc_d = '0;
    else if (add_en) acc_d = folded;
    csum_ok = (folded == 16'hFFFF);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule

// File: rtl/ip_udp_rx.sv
// IPv4 receive stage: parses/validates the IPv4 header, strips header and
// options, forwards the UDP datagram on a byte stream and trims padding.
//   clk, reset_n           : clock, async active-low reset
//   ip_axis_*              : IPv4 packet bytes in (tlast = end of Ethernet payload)
//   udp_axis_*             : UDP datagram bytes out (tlast = end of IP payload)
//   ip_src_out             : source IP of the last accepted packet
//   ip_payload_len_out     : Total Length - IHL*4 of the last accepted packet
//   pkt_drop_out           : 1-cycle pulse per dropped packet
//   trunc_err_out          : 1-cycle pulse when input ends before Total Length
//
// state   | meaning
// HDR     | consuming header + options, accumulating checksum
// PAYLOAD | forwarding datagram bytes, counting down remaining length
// DROP    | discarding bytes (rejected packet or padding) until tlast
module ip_udp_rx
  import ip_rx_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0102,
  parameter bit          CHECK_DST  = 1'b1,
  parameter bit          CHECK_CSUM = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  ip_axis_tdata_in,
  input  logic        ip_axis_tvalid_in,
  input  logic        ip_axis_tlast_in,
  output logic        ip_axis_tready_out,
  output logic [7:0]  udp_axis_tdata_out,
  output logic        udp_axis_tvalid_out,
  output logic        udp_axis_tlast_out,
  input  logic        udp_axis_tready_in,
  output logic [31:0] ip_src_out,
  output logic [15:0] ip_payload_len_out,
  output logic        pkt_drop_out,
  output logic        trunc_err_out
);

  ip_rx_state_e state_q, state_d;
  logic [15:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0]  rem_q, rem_d;
  logic [3:0]   ver_q, ver_d, ihl_q, ihl_d;
  logic [15:0]  tot_len_q, tot_len_d;
  logic         mf_q, mf_d;
  logic [12:0]  frag_q, frag_d;
  logic [7:0]   proto_q, proto_d;
  logic [31:0]  src_q, src_d, dst_q, dst_d;
  logic         rdy_q;
  logic         out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [7:0]   out_data_q, out_data_d;
  logic [31:0]  ip_src_q, ip_src_d;
  logic [15:0]  pay_len_q, pay_len_d;
  logic         drop_q, drop_d, trunc_q, trunc_d;

  logic         xfer, tlast, in_hdr, csum_ok, hdr_last, accept;
  logic [3:0]   ihl_eff;
  logic [15:0]  hdr_len, pay_len, min_len;
  logic [31:0]  dst_eff;

  // rdy_q keeps tready low while in reset so every output reads 0 there
  assign ip_axis_tready_out = rdy_q & ((state_q != PAYLOAD) | ~out_valid_q | udp_axis_tready_in);
  assign xfer   = ip_axis_tvalid_in & ip_axis_tready_out;
  assign tlast  = ip_axis_tlast_in;
  assign in_hdr = (state_q == HDR);

  // IHL is only captured at the end of byte 0, so byte 0 uses the live value.
  // An illegal IHL still runs to byte 19 before being rejected.
  assign ihl_eff  = (byte_cnt_q == OFF_VER_IHL) ? ip_axis_tdata_in[3:0] : ihl_q;
  assign hdr_len  = (ihl_eff < IP_MIN_IHL) ? MIN_HDR_LEN : {10'd0, ihl_eff, 2'b00};
  assign hdr_last = (byte_cnt_q == hdr_len - 16'd1);
  assign pay_len  = tot_len_q - hdr_len;
  assign min_len  = hdr_len + UDP_HDR_LEN;
  // With IHL=5 the last dst byte is the decision byte itself
  assign dst_eff  = (byte_cnt_q == OFF_DST3) ? {dst_q[31:8], ip_axis_tdata_in} : dst_q;

  assign accept = (ver_q == IP_VERSION4) && (ihl_q >= IP_MIN_IHL) && (proto_q == IP_PROTO_UDP)
                  && !mf_q && (frag_q == 13'd0) && (tot_len_q >= min_len)
                  && (!CHECK_CSUM || csum_ok)
                  && (!CHECK_DST || dst_eff == LOCAL_IP || dst_eff == 32'hFFFF_FFFF);

  ip_hdr_csum u_csum (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (xfer & in_hdr & (hdr_last | tlast)),
    .add_en  (xfer & in_hdr),
    .odd_sel (byte_cnt_q[0]),
    .byte_in (ip_axis_tdata_in),
    .csum_ok (csum_ok)
  );

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    rem_d       = rem_q;
    ver_d       = ver_q;
    ihl_d       = ihl_q;
    tot_len_d   = tot_len_q;
    mf_d        = mf_q;
    frag_d      = frag_q;
    proto_d     = proto_q;
    src_d       = src_q;
    dst_d       = dst_q;
    out_valid_d = out_valid_q & ~udp_axis_tready_in;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    ip_src_d    = ip_src_q;
    pay_len_d   = pay_len_q;
    drop_d      = 1'b0;
    trunc_d     = 1'b0;

    case (state_q)
      HDR: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          case (byte_cnt_q)
            OFF_VER_IHL:   begin ver_d = ip_axis_tdata_in[7:4]; ihl_d = ip_axis_tdata_in[3:0]; end
            OFF_TOTLEN_HI: tot_len_d[15:8] = ip_axis_tdata_in;
            OFF_TOTLEN_LO: tot_len_d[7:0]  = ip_axis_tdata_in;
            OFF_FRAG_HI:   begin mf_d = ip_axis_tdata_in[5]; frag_d[12:8] = ip_axis_tdata_in[4:0]; end
            OFF_FRAG_LO:   frag_d[7:0]     = ip_axis_tdata_in;
            OFF_PROTO:     proto_d         = ip_axis_tdata_in;
            OFF_SRC0:      src_d[31:24]    = ip_axis_tdata_in;
            OFF_SRC1:      src_d[23:16]    = ip_axis_tdata_in;
            OFF_SRC2:      src_d[15:8]     = ip_axis_tdata_in;
            OFF_SRC3:      src_d[7:0]      = ip_axis_tdata_in;
            OFF_DST0:      dst_d[31:24]    = ip_axis_tdata_in;
            OFF_DST1:      dst_d[23:16]    = ip_axis_tdata_in;
            OFF_DST2:      dst_d[15:8]     = ip_axis_tdata_in;
            OFF_DST3:      dst_d[7:0]      = ip_axis_tdata_in;
            default: ;
          endcase
          if (hdr_last || tlast) begin
            byte_cnt_d = '0;
            // a packet ending exactly on its last header byte has no
            // datagram to forward, so it is dropped even if otherwise valid
            if (hdr_last && accept && !tlast) begin
              state_d   = PAYLOAD;
              rem_d     = pay_len;
              ip_src_d  = src_q;
              pay_len_d = pay_len;
            end else begin
              drop_d  = 1'b1;
              state_d = tlast ? HDR : DROP;
            end
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          out_valid_d = 1'b1;
          out_data_d  = ip_axis_tdata_in;
          out_last_d  = (rem_q == 16'd1) | tlast;
          rem_d       = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = tlast ? HDR : DROP;
          end else if (tlast) begin
            trunc_d = 1'b1;
            state_d = HDR;
          end
        end
      end
      DROP: begin
        if (xfer && tlast) state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HDR;
      byte_cnt_q  <= '0;
      rem_q       <= '0;
      ver_q       <= '0;
      ihl_q       <= '0;
      tot_len_q   <= '0;
      mf_q        <= 1'b0;
      frag_q      <= '0;
      proto_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      rdy_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      ip_src_q    <= '0;
      pay_len_q   <= '0;
      drop_q      <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      rem_q       <= rem_d;
      ver_q       <= ver_d;
      ihl_q       <= ihl_d;
      tot_len_q   <= tot_len_d;
      mf_q        <= mf_d;
      frag_q      <= frag_d;
      proto_q     <= proto_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rdy_q       <= 1'b1;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      ip_src_q    <= ip_src_d;
      pay_len_q   <= pay_len_d;
      drop_q      <= drop_d;
      trunc_q     <= trunc_d;
    end
  end

  assign udp_axis_tdata_out  = out_data_q;
  assign udp_axis_tvalid_out = out_valid_q;
  assign udp_axis_tlast_out  = out_last_q;
  assign ip_src_out          = ip_src_q;
  assign ip_payload_len_out  = pay_len_q;
  assign pkt_drop_out        = drop_q;
  assign trunc_err_out       = trunc_q;

endmodule

// File: tb/tb_ip_udp_rx.sv
module tb_ip_udp_rx;
  localparam logic [31:0] LOCAL_IP = 32'hC0A8_0102;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  ip_tdata = '0;
  logic        ip_tvalid = 1'b0, ip_tlast = 1'b0, ip_tready;
  logic [7:0]  udp_tdata;
  logic        udp_tvalid, udp_tlast;
  logic        udp_tready = 1'b1;
  logic [31:0] ip_src;
  logic [15:0] ip_len;
  logic        pkt_drop, trunc_err;

  ip_udp_rx dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .ip_axis_tdata_in    (ip_tdata),
    .ip_axis_tvalid_in   (ip_tvalid),
    .ip_axis_tlast_in    (ip_tlast),
    .ip_axis_tready_out  (ip_tready),
    .udp_axis_tdata_out  (udp_tdata),
    .udp_axis_tvalid_out (udp_tvalid),
    .udp_axis_tlast_out  (udp_tlast),
    .udp_axis_tready_in  (udp_tready),
    .ip_src_out          (ip_src),
    .ip_payload_len_out  (ip_len),
    .pkt_drop_out        (pkt_drop),
    .trunc_err_out       (trunc_err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] pkt[$];
  logic [8:0] exp_q[$];
  int exp_drop = 0, exp_trunc = 0, act_drop = 0, act_trunc = 0;
  bit exp_acc;
  logic [31:0] exp_src;
  logic [15:0] exp_len;
  bit rand_rdy = 0;
  bit lat_arm = 0;
  int lat_idx = -1, lat_in_cyc = -1, lat_out_cyc = -1;
  bit hold_pend = 0;
  logic [8:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Build an IPv4 packet with a correct header checksum (optionally spoiled)
  task automatic build(input int ver, input int ihl, input int tot, input int proto,
                       input int flags, input logic [31:0] dst, input int nbytes, input bit bad_cs);
    int hl, sum;
    logic [15:0] cs;
    logic [31:0] src;
    hl = (ihl < 5) ? 20 : ihl * 4;
    pkt.delete();
    for (int i = 0; i < hl; i++) pkt.push_back(8'($urandom));
    pkt[0] = 8'((ver << 4) | ihl);
    pkt[1] = 8'h00;
    pkt[2] = 8'(tot >> 8);   pkt[3] = 8'(tot);
    pkt[6] = 8'(flags >> 8); pkt[7] = 8'(flags);
    pkt[8] = 8'd64;          pkt[9] = 8'(proto);
    pkt[10] = 8'h00;         pkt[11] = 8'h00;
    src = $urandom;
    for (int k = 0; k < 4; k++) begin
      pkt[12 + k] = 8'(src >> (24 - 8 * k));
      pkt[16 + k] = 8'(dst >> (24 - 8 * k));
    end
    sum = 0;
    for (int i = 0; i < hl; i += 2) sum += int'(pkt[i]) * 256 + int'(pkt[i + 1]);
    while (sum > 65535) sum = (sum & 65535) + (sum >> 16);
    cs = ~16'(sum);
    pkt[10] = cs[15:8];
    pkt[11] = cs[7:0];
    if (bad_cs) pkt[10] = ~pkt[10];
    while (pkt.size() < nbytes) pkt.push_back(8'($urandom));
  endtask

  // Reference model: decides the fate of the first `size` bytes of pkt
  task automatic model(input int size);
    int ver, ihl, hl, tot, sum, plen, n;
    logic [31:0] dst, src;
    bit ok;
    exp_acc = 0;
    ver = int'(pkt[0][7:4]);
    ihl = int'(pkt[0][3:0]);
    hl  = (ihl < 5) ? 20 : 4 * ihl;
    if (size <= hl) begin exp_drop++; return; end
    tot = int'(pkt[2]) * 256 + int'(pkt[3]);
    sum = 0;
    for (int i = 0; i < hl; i += 2) sum += int'(pkt[i]) * 256 + int'(pkt[i + 1]);
    while (sum > 65535) sum = (sum & 65535) + (sum >> 16);
    dst = {pkt[16], pkt[17], pkt[18], pkt[19]};
    src = {pkt[12], pkt[13], pkt[14], pkt[15]};
    ok = (ver == 4) && (ihl >= 5) && (pkt[9] == 8'd17) && (pkt[6][5] == 1'b0)
         && (pkt[6][4:0] == 5'd0) && (pkt[7] == 8'd0) && (tot >= hl + 8)
         && (sum == 65535) && (dst == LOCAL_IP || dst == 32'hFFFF_FFFF);
    if (!ok) begin exp_drop++; return; end
    plen = tot - hl;
    n = (size - hl < plen) ? size - hl : plen;
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), pkt[hl + i]});
    if (size - hl < plen) exp_trunc++;
    exp_acc = 1;
    exp_src = src;
    exp_len = 16'(plen);
  endtask

  task automatic send_bytes(input int n, input bit last_on_end);
    int t;
    for (int i = 0; i < n; i++) begin
      ip_tdata  = pkt[i];
      ip_tlast  = last_on_end && (i == n - 1);
      ip_tvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!ip_tready && t < 200);
      if (!ip_tready) begin
        n_cmp++; n_bad++;
        $display("FAIL input_ready_timeout: tready stayed 0 at byte %0d, required 1", i);
        ip_tvalid = 1'b0; ip_tlast = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (i == lat_idx) lat_in_cyc = cyc;
    end
    ip_tvalid = 1'b0;
    ip_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d bytes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    chk("drop_count", 64'(act_drop), 64'(exp_drop));
    chk("trunc_count", 64'(act_trunc), 64'(exp_trunc));
    if (exp_acc) begin
      chk("payload_len", 64'(ip_len), 64'(exp_len));
      chk("src_ip", 64'(ip_src), 64'(exp_src));
    end
    @(posedge clk); #1;
  endtask

  task automatic run_pkt(input int size);
    model(size);
    send_bytes(size, 1'b1);
    drain();
  endtask

  // Output readiness
  initial forever begin
    @(posedge clk); #1;
    udp_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      hold_pend = 0;
    end else begin
      if (hold_pend) chk("hold_stable", 64'({udp_tvalid, udp_tlast, udp_tdata}), 64'({1'b1, held}));
      if (udp_tvalid && udp_tready) begin
        hold_pend = 0;
        if (lat_arm && lat_out_cyc < 0) lat_out_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: got %0h, required no output", {udp_tlast, udp_tdata});
        end else begin
          chk("out_byte", 64'({udp_tlast, udp_tdata}), 64'(exp_q.pop_front()));
        end
      end else if (udp_tvalid) begin
        hold_pend = 1;
        held = {udp_tlast, udp_tdata};
      end else begin
        hold_pend = 0;
      end
      if (pkt_drop)  act_drop++;
      if (trunc_err) act_trunc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ihl, hl, plen, tot, kind, size, r, ver, proto, flags;
    logic [31:0] dst;
    #2 reset_n = 1'b0;
    #1 chk("reset_outputs", {3'd0, udp_tvalid, udp_tlast, ip_tready, pkt_drop, trunc_err, udp_tdata, ip_len, ip_src}, 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: plain valid packet, latency check
    build(4, 5, 36, 17, 0, LOCAL_IP, 36, 0);
    lat_idx = 20; lat_arm = 1; lat_out_cyc = -1;
    run_pkt(36);
    chk("latency", 64'(lat_out_cyc), 64'(lat_in_cyc));
    lat_arm = 0; lat_idx = -1;

    // 2: padding trimmed
    build(4, 5, 36, 17, 16'h4000, LOCAL_IP, 46, 0);
    run_pkt(46);

    // 3: TCP dropped, corrupt checksum dropped, each followed by a good one
    build(4, 5, 36, 6, 0, LOCAL_IP, 36, 0);  run_pkt(36);
    build(4, 5, 36, 17, 0, LOCAL_IP, 36, 0); run_pkt(36);
    build(4, 5, 36, 17, 0, LOCAL_IP, 36, 1); run_pkt(36);
    build(4, 5, 36, 17, 0, LOCAL_IP, 36, 0); run_pkt(36);

    // 4: options stripped
    build(4, 6, 40, 17, 0, LOCAL_IP, 40, 0); run_pkt(40);

    // 5: truncated packet
    build(4, 5, 48, 17, 0, LOCAL_IP, 36, 0); run_pkt(36);

    // 6: random output backpressure on case 1
    rand_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      build(4, 5, 36, 17, 0, LOCAL_IP, 36, 0); run_pkt(36);
    end

    // randomized packet mix
    for (int k = 0; k < 40; k++) begin
      rand_rdy = 1'($urandom_range(0, 1));
      ihl  = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(5, 7);
      hl   = (ihl < 5) ? 20 : ihl * 4;
      plen = 8 + $urandom_range(0, 20);
      tot  = hl + plen;
      ver = 4; proto = 17; flags = ($urandom_range(0, 1) != 0) ? 16'h4000 : 0; dst = LOCAL_IP;
      kind = $urandom_range(0, 9);
      case (kind)
        0: proto = 6;
        1: dst = $urandom;
        2: flags = 16'h2000;
        4: ver = 6;
        5: dst = 32'hFFFF_FFFF;
        6: begin tot = hl + 4; flags = 16'h0005; end
        default: ;
      endcase
      if (kind == 6) flags = ($urandom_range(0, 1) != 0) ? 16'h0005 : 0;
      r = $urandom_range(0, 3);
      case (r)
        0: size = tot - $urandom_range(1, plen);
        1: size = $urandom_range(1, hl - 1);
        2: size = tot + $urandom_range(1, 10);
        default: size = tot;
      endcase
      build(ver, ihl, tot, proto, flags, dst, (size > hl) ? size : hl, kind == 3);
      run_pkt(size);
    end

    // async reset mid-payload, then a clean packet
    rand_rdy = 0;
    build(4, 5, 36, 17, 0, LOCAL_IP, 36, 0);
    model(36);
    send_bytes(26, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk("midreset_outputs", {3'd0, udp_tvalid, udp_tlast, ip_tready, pkt_drop, trunc_err, udp_tdata, ip_len, ip_src}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    build(4, 5, 36, 17, 0, LOCAL_IP, 36, 0);
    run_pkt(36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
